// File: rtl/blanket_check.sv
// MBIST blanket read-back verify: sweeps every address, compares each word against the
// written background and reports pass/fail, mismatch count and the first failing address.
module blanket_check #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              rev_in,
    input  logic [DATA_W-1:0] rd_data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              r_en_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              pass_out,
    output logic              err_out,
    output logic [ADDR_W:0]   fail_cnt_out,
    output logic [ADDR_W-1:0] fail_addr_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0] NUM_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [2:0]      DRAIN_LAST = 3'(RD_LAT - 1);

    logic [1:0]        state;
    logic [ADDR_W:0]   addr_cnt;
    logic [2:0]        drain_cnt;
    logic              rev_q;
    logic [RD_LAT-1:0] vld_pipe;
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];
    logic              accept;
    logic              mismatch;

    // The done_out cycle is still part of the sweep, so a start there is ignored.
    assign accept   = (state == S_IDLE) && start_in && !done_out;
    assign mismatch = vld_pipe[RD_LAT-1] && (rd_data_in != {DATA_W{rev_q}});

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= r_en_out;
            addr_pipe[0] <= addr_out;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            addr_cnt      <= '0;
            drain_cnt     <= '0;
            rev_q         <= 1'b0;
            addr_out      <= '0;
            r_en_out      <= 1'b0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            pass_out      <= 1'b0;
            err_out       <= 1'b0;
            fail_cnt_out  <= '0;
            fail_addr_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (done_out) begin
                        done_out <= 1'b0;
                        busy_out <= 1'b0;
                    end else if (start_in) begin
                        state    <= S_READ;
                        rev_q    <= rev_in;
                        busy_out <= 1'b1;
                        r_en_out <= 1'b1;
                        addr_out <= '0;
                        addr_cnt <= {{ADDR_W{1'b0}}, 1'b1};
                        pass_out <= 1'b0;
                    end
                end
                S_READ: begin
                    // addr_cnt runs one ahead of addr_out; the extra MSB marks the end of the sweep.
                    if (addr_cnt == NUM_WORDS) begin
                        state     <= S_DRAIN;
                        r_en_out  <= 1'b0;
                        addr_out  <= '0;
                        drain_cnt <= '0;
                    end else begin
                        addr_out <= addr_cnt[ADDR_W-1:0];
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_out <= 1'b1;
                    pass_out <= (fail_cnt_out == '0);
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                err_out       <= 1'b0;
                fail_cnt_out  <= '0;
                fail_addr_out <= '0;
            end else if (mismatch) begin
                fail_cnt_out <= fail_cnt_out + 1'b1;
                if (!err_out) begin
                    err_out       <= 1'b1;
                    fail_addr_out <= addr_pipe[RD_LAT-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_blanket_check.sv
// Bench for blanket_check: RD_LAT=1 and RD_LAT=3 instances swept against a shared memory image.
module tb_blanket_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       rev;
    logic       start1, start3;
    logic [3:0] rd1, rd3;
    logic [7:0] addr1, addr3, faddr1, faddr3;
    logic       ren1, ren3, busy1, busy3, done1, done3, pass1, pass3, err1, err3;
    logic [8:0] cnt1, cnt3;

    always #5 clk = ~clk;

    blanket_check #(.ADDR_W(8), .DATA_W(4), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start_in(start1), .rev_in(rev), .rd_data_in(rd1),
        .addr_out(addr1), .r_en_out(ren1), .busy_out(busy1), .done_out(done1),
        .pass_out(pass1), .err_out(err1), .fail_cnt_out(cnt1), .fail_addr_out(faddr1)
    );

    blanket_check #(.ADDR_W(8), .DATA_W(4), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start_in(start3), .rev_in(rev), .rd_data_in(rd3),
        .addr_out(addr3), .r_en_out(ren3), .busy_out(busy3), .done_out(done3),
        .pass_out(pass3), .err_out(err3), .fail_cnt_out(cnt3), .fail_addr_out(faddr3)
    );

    // Memory models with 1 and 3 cycles of read latency.
    logic [3:0] mem [256];
    logic [3:0] p1;
    logic [3:0] p3 [3];
    always @(posedge clk) begin
        p1    <= mem[addr1];
        p3[0] <= mem[addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd1 = p1;
    assign rd3 = p3[2];

    int checks   = 0;
    int failures = 0;
    bit mism [256];
    int model_tot;
    int model_first;

    typedef struct {
        logic       rev;
        logic [3:0] fill;
        int         fa0;
        logic [3:0] fv0;
        int         fa1;
        logic [3:0] fv1;
        bit         noise;
        int         exp_cnt;
        int         exp_addr;
        bit         exp_pass;
        bit         exp_err;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [3:0] fill, input int fa0, input logic [3:0] fv0,
                            input int fa1, input logic [3:0] fv1);
        for (int k = 0; k < 256; k++) mem[k] = fill;
        if (fa0 >= 0) mem[fa0] = fv0;
        if (fa1 >= 0) mem[fa1] = fv1;
    endtask

    // n = edges elapsed since the accepting edge; data for address k is judged at edge k+L+1.
    task automatic check_cycle(input int L, input int n, input logic ren, input logic [7:0] a,
                               input logic busy, input logic done, input logic pass,
                               input logic err, input logic [8:0] cnt, input logic [7:0] fa);
        int cnt_e;
        int first_e;
        cnt_e   = 0;
        first_e = 0;
        for (int k = 0; k < 256; k++) begin
            if (mism[k] && (k + L + 1 <= n)) begin
                if (cnt_e == 0) first_e = k;
                cnt_e++;
            end
        end
        chk($sformatf("L%0d n%0d r_en", L, n), ren, (n <= 255) ? 1 : 0);
        chk($sformatf("L%0d n%0d addr", L, n), a, (n <= 255) ? n : 0);
        chk($sformatf("L%0d n%0d busy", L, n), busy, (n <= 257 + L) ? 1 : 0);
        chk($sformatf("L%0d n%0d done", L, n), done, (n == 257 + L) ? 1 : 0);
        chk($sformatf("L%0d n%0d pass", L, n), pass, (n >= 257 + L && model_tot == 0) ? 1 : 0);
        chk($sformatf("L%0d n%0d err", L, n), err, (cnt_e > 0) ? 1 : 0);
        chk($sformatf("L%0d n%0d fail_cnt", L, n), cnt, cnt_e);
        chk($sformatf("L%0d n%0d fail_addr", L, n), fa, first_e);
    endtask

    task automatic sweep(input logic r, input bit noise);
        logic [3:0] bg;
        bg          = r ? 4'hF : 4'h0;
        model_tot   = 0;
        model_first = -1;
        for (int k = 0; k < 256; k++) begin
            mism[k] = (mem[k] != bg);
            if (mism[k]) begin
                if (model_first < 0) model_first = k;
                model_tot++;
            end
        end
        if (model_first < 0) model_first = 0;
        start1 = 1'b1;
        start3 = 1'b1;
        rev    = r;
        @(posedge clk);
        for (int n = 0; n <= 262; n++) begin
            @(negedge clk);
            if (noise && n <= 257) begin
                start1 = 1'($urandom);
                start3 = 1'($urandom);
                rev    = 1'($urandom);
            end else begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
            check_cycle(1, n, ren1, addr1, busy1, done1, pass1, err1, cnt1, faddr1);
            check_cycle(3, n, ren3, addr3, busy3, done3, pass3, err3, cnt3, faddr3);
        end
    endtask

    task automatic wait_done1(output int m);
        m = 0;
        while (!done1 && m < 400) begin
            @(negedge clk);
            m++;
        end
    endtask

    initial begin
        int m;
        vecs[0] = '{1'b0, 4'h0, -1,   4'h0, -1,   4'h0, 1'b0, 0,   0,   1'b1, 1'b0};
        vecs[1] = '{1'b1, 4'hF, 'h37, 4'hB, 'hC0, 4'h0, 1'b0, 2,   'h37, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 4'hF, -1,   4'h0, -1,   4'h0, 1'b0, 256, 0,   1'b0, 1'b1};
        vecs[3] = '{1'b1, 4'hF, 'h37, 4'hB, 'hC0, 4'h0, 1'b1, 2,   'h37, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 4'h0, 'hFF, 4'h1, -1,   4'h0, 1'b0, 1,   'hFF, 1'b0, 1'b1};

        // Reset wins over a coincident start.
        rst    = 1'b1;
        start1 = 1'b1;
        start3 = 1'b1;
        rev    = 1'b1;
        load_mem(4'h0, -1, 4'h0, -1, 4'h0);
        repeat (3) @(negedge clk);
        chk("reset outputs L1", int'({addr1, ren1, busy1, done1, pass1, err1, cnt1, faddr1}), 0);
        chk("reset outputs L3", int'({addr3, ren3, busy3, done3, pass3, err3, cnt3, faddr3}), 0);
        rst    = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            load_mem(vecs[i].fill, vecs[i].fa0, vecs[i].fv0, vecs[i].fa1, vecs[i].fv1);
            sweep(vecs[i].rev, vecs[i].noise);
            chk($sformatf("vec%0d L1 fail_cnt", i), cnt1, vecs[i].exp_cnt);
            chk($sformatf("vec%0d L1 fail_addr", i), faddr1, vecs[i].exp_addr);
            chk($sformatf("vec%0d L1 pass", i), pass1, vecs[i].exp_pass);
            chk($sformatf("vec%0d L1 err", i), err1, vecs[i].exp_err);
            chk($sformatf("vec%0d L3 fail_cnt", i), cnt3, vecs[i].exp_cnt);
            chk($sformatf("vec%0d L3 fail_addr", i), faddr3, vecs[i].exp_addr);
            chk($sformatf("vec%0d L3 pass", i), pass3, vecs[i].exp_pass);
            chk($sformatf("vec%0d L3 err", i), err3, vecs[i].exp_err);
        end

        // Start during the done_out cycle is dropped; one cycle later it is taken.
        load_mem(4'h0, -1, 4'h0, -1, 4'h0);
        rev    = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        wait_done1(m);
        chk("done latency L1", m, 258);
        start1 = 1'b1;
        @(negedge clk);
        chk("start in done cycle r_en", ren1, 0);
        chk("start in done cycle busy", busy1, 0);
        @(negedge clk);
        start1 = 1'b0;
        chk("start after done r_en", ren1, 1);
        chk("start after done addr", addr1, 0);
        chk("start after done busy", busy1, 1);
        chk("start after done pass cleared", pass1, 0);
        wait_done1(m);
        chk("second done latency L1", m, 258);
        chk("second sweep pass", pass1, 1);
        chk("second sweep fail_cnt", cnt1, 0);
        repeat (2) @(negedge clk);

        // Mid-sweep reset at address 100 on a failing image, then a clean sweep.
        load_mem(4'hF, -1, 4'h0, -1, 4'h0);
        rev    = 1'b0;
        start1 = 1'b1;
        start3 = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 100; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            start3 = 1'b0;
        end
        chk("pre-reset addr L1", addr1, 100);
        chk("pre-reset addr L3", addr3, 100);
        chk("pre-reset err L1", err1, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset outputs L1", int'({addr1, ren1, busy1, done1, pass1, err1, cnt1, faddr1}), 0);
        chk("mid reset outputs L3", int'({addr3, ren3, busy3, done3, pass3, err3, cnt3, faddr3}), 0);
        rst = 1'b0;
        load_mem(4'h0, -1, 4'h0, -1, 4'h0);
        sweep(1'b0, 1'b0);
        chk("post-reset pass L1", pass1, 1);
        chk("post-reset pass L3", pass3, 1);
        chk("post-reset fail_cnt L3", cnt3, 0);

        // Random images against the reference model.
        for (int it = 0; it < 3; it++) begin
            logic r;
            r = 1'($urandom);
            for (int k = 0; k < 256; k++) begin
                mem[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : (r ? 4'hF : 4'h0);
            end
            sweep(r, 1'b1);
            chk($sformatf("rand%0d L1 fail_cnt", it), cnt1, model_tot);
            chk($sformatf("rand%0d L3 fail_addr", it), faddr3, model_first);
            chk($sformatf("rand%0d L3 pass", it), pass3, (model_tot == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/blanket_check.md
# blanket_check

Read-back verify stage for the MBIST blanket pass. Runs after the blanket background writer reports completion. Sweeps every memory address with a read, compares each returned word against the expected background (all-zeros or all-ones) and reports a pass/fail verdict, mismatch count and first failing address to the MBIST controller.

## Interface
- `ADDR_W`, default 8: address width; sweep covers 2^ADDR_W words.
- `DATA_W`, default 4: memory word width.
- `RD_LAT`, default 1: cycles from `addr_out`/`r_en_out` to valid `rd_data_in`; legal range 1–4.

- `clk`, in, 1: single clock; all state updates on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `start_in`, in, 1: start request, driven from the writer's `rst_done`; accepted only in IDLE.
- `rev_in`, in, 1: background select; 0 expects all-zeros, 1 expects all-ones; sampled only when start is accepted.
- `rd_data_in`, in, DATA_W: memory read data.
- `addr_out`, out, ADDR_W: read address.
- `r_en_out`, out, 1: read enable.
- `busy_out`, out, 1: high from the cycle after start acceptance until `done_out` goes low.
- `done_out`, out, 1: one-cycle completion pulse.
- `pass_out`, out, 1: 1 when the last sweep had zero mismatches; valid from `done_out`, held until next start.
- `err_out`, out, 1: sticky; set on the first mismatch of a sweep.
- `fail_cnt_out`, out, ADDR_W+1: mismatch count for the sweep; 0 to 2^ADDR_W.
- `fail_addr_out`, out, ADDR_W: address of the first mismatch; 0 if none.

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states:
  - IDLE: on `start_in`, go to READ. Latch `rev_in` as the expected pattern. Clear `pass_out`, `err_out`, `fail_cnt_out`, `fail_addr_out`.
  - READ: drive `r_en_out`=1 and `addr_out` = 0, 1, …, 2^ADDR_W−1, one address per cycle. After the last address, go to DRAIN.
  - DRAIN: `r_en_out`=0, `addr_out`=0. Stay RD_LAT cycles to collect outstanding reads, then go to DONE.
  - DONE: assert `done_out` for one cycle. Set `pass_out` = (`fail_cnt_out`==0). Return to IDLE.
- Compare pipeline:
  - Delay `r_en_out` and `addr_out` through an RD_LAT-deep shift register.
  - When the delayed valid is set, compare `rd_data_in` against {DATA_W{rev}} using full-width equality.
  - On mismatch, increment `fail_cnt_out`. If `err_out` was 0, also set `err_out` and load `fail_addr_out` with the delayed address.
- Address counter is ADDR_W+1 bits internally so that terminal detection does not alias at wrap. `addr_out` never wraps past 2^ADDR_W−1 within a sweep.
- `start_in` is ignored in READ, DRAIN and DONE.
- `rev_in` changes after acceptance have no effect.
- `rst` takes priority over everything, including a coincident `start_in`. Mid-sweep reset returns to IDLE with all outputs 0 on the next cycle and discards compare pipeline contents.

## Timing
- Start accepted at edge T.
- First `r_en_out`=1 with `addr_out`=0 in the cycle after edge T; address k is presented after edge T+k.
- `r_en_out` is high for exactly 2^ADDR_W consecutive cycles.
- Data for address k is compared at edge T+k+RD_LAT+1.
- Last compare is at edge T+2^ADDR_W+RD_LAT. `done_out` is high in the following cycle.
- Start-to-done latency is 2^ADDR_W+RD_LAT+1 cycles (258 at defaults).
- A new start is accepted at earliest in the cycle after `done_out`.
- `fail_cnt_out` and `err_out` update in the cycle after the mismatching data.

## Test plan
- Reset, then start with rev=0 on an all-0000 memory model (RD_LAT=1): 256 reads for addresses 0..255 in order; `done_out` pulse 258 cycles after start; `pass_out`=1, `err_out`=0, `fail_cnt_out`=0.
- rev=1, memory all 1111 except 0x37=1011 and 0xC0=0000: `fail_cnt_out`=2, `fail_addr_out`=0x37, `err_out`=1, `pass_out`=0.
- rev=0, memory all 1111: `fail_cnt_out`=256 (0x100), `fail_addr_out`=0x00, `pass_out`=0.
- Extra `start_in` pulses and `rev_in` toggles during READ and DRAIN: ignored. Result matches the clean run; `start_in` during the `done_out` cycle is ignored; a start one cycle later is accepted.
- Assert `rst` while `addr_out`=100: next cycle all outputs 0. A subsequent start gives a complete correct sweep with no stale failures.
- RD_LAT=3 with a single fault at 0xFF: `done_out` 260 cycles after start; `fail_addr_out`=0xFF, `fail_cnt_out`=1.
